// File: rtl/neighbor_scan_ctrl.sv
// Routing-round sequencer: scans the neighbor table for the lowest-cost entry,
// then hands the candidate to winnerPolicy and captures its result.
module neighbor_scan_ctrl #(
    parameter int ADDR_WIDTH    = 10,
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 64,
    parameter int WP_TIMEOUT    = 255
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] table_base,
    input  logic [WORD_WIDTH-1:0] my_node_id,
    input  logic [WORD_WIDTH-1:0] eps_init,
    input  logic                  eps_load,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic [WORD_WIDTH-1:0] wp_epsilon,
    output logic [WORD_WIDTH-1:0] wp_mybest,
    output logic [WORD_WIDTH-1:0] wp_besthop,
    output logic [WORD_WIDTH-1:0] wp_bestvalue,
    output logic [WORD_WIDTH-1:0] wp_bestneighborID,
    output logic [WORD_WIDTH-1:0] wp_my_node_id,
    output logic                  wp_done_prev,
    input  logic                  wp_done,
    input  logic [WORD_WIDTH-1:0] wp_nexthop,
    input  logic [WORD_WIDTH-1:0] wp_epsilon_step,
    output logic                  busy,
    output logic                  round_done,
    output logic [WORD_WIDTH-1:0] nexthop,
    output logic                  no_route,
    output logic                  timeout
);

    localparam int CW = $clog2(MAX_NEIGHBORS * 4 + 1);
    localparam int TW = $clog2(WP_TIMEOUT + 1);
    localparam logic [WORD_WIDTH-1:0] COST_INF = 16'h7C00;

    typedef enum logic [2:0] {IDLE, CNT, SCAN, KICK, WAIT, DONE} state_t;

    state_t                state, state_d;
    logic [1:0]            phase;
    logic [7:0]            cnt_hi;
    logic [CW-1:0]         tot, rd_cnt, samp_cnt;
    logic                  rd_q;
    logic [WORD_WIDTH-1:0] cur_id, run_val, run_id;
    logic [7:0]            val_hi;
    logic [TW-1:0]         wait_cnt;

    logic [15:0]           n_raw, n_clamped;
    logic [17:0]           n_bytes;
    logic [WORD_WIDTH-1:0] cand;
    logic                  better, last_sample, timed_out;

    always_ff @(posedge clock) begin
        if (nreset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d      = state;
        mem_rd       = 1'b0;
        wp_done_prev = 1'b0;
        n_raw        = {cnt_hi, mem_rdata};
        n_clamped    = (n_raw > 16'(MAX_NEIGHBORS)) ? 16'(MAX_NEIGHBORS) : n_raw;
        n_bytes      = {n_clamped, 2'b00};
        cand         = {val_hi, mem_rdata};
        better       = cand < run_val;
        last_sample  = rd_q && (samp_cnt == tot - CW'(1));
        timed_out    = wait_cnt == TW'(WP_TIMEOUT - 1);
        case (state)
            IDLE: if (start) state_d = CNT;
            CNT: begin
                mem_rd = (phase != 2'd2);
                if (phase == 2'd2) state_d = (n_raw == '0) ? DONE : SCAN;
            end
            SCAN: begin
                mem_rd = (rd_cnt != tot);
                if (last_sample) state_d = KICK;
            end
            KICK: begin
                wp_done_prev = 1'b1;
                state_d      = WAIT;
            end
            WAIT: if (wp_done || timed_out) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign round_done = (state == DONE);

    always_ff @(posedge clock) begin
        if (nreset) begin
            phase             <= '0;
            cnt_hi            <= '0;
            tot               <= '0;
            rd_cnt            <= '0;
            samp_cnt          <= '0;
            rd_q              <= 1'b0;
            cur_id            <= '0;
            val_hi            <= '0;
            run_val           <= COST_INF;
            run_id            <= '0;
            wait_cnt          <= '0;
            mem_addr          <= '0;
            wp_epsilon        <= '0;
            wp_mybest         <= COST_INF;
            wp_besthop        <= '0;
            wp_bestvalue      <= '0;
            wp_bestneighborID <= '0;
            wp_my_node_id     <= '0;
            nexthop           <= '0;
            no_route          <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            wp_my_node_id <= my_node_id;
            case (state)
                IDLE: begin
                    if (eps_load) wp_epsilon <= eps_init;
                    if (start) begin
                        mem_addr <= table_base;
                        phase    <= '0;
                        no_route <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end
                CNT: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd0) mem_addr <= mem_addr + 1'b1;
                    if (phase == 2'd1) cnt_hi <= mem_rdata;
                    if (phase == 2'd2) begin
                        tot      <= CW'(n_bytes);
                        rd_cnt   <= '0;
                        samp_cnt <= '0;
                        rd_q     <= 1'b0;
                        run_val  <= COST_INF;
                        run_id   <= '0;
                        if (n_raw == '0) no_route <= 1'b1;
                        else             mem_addr <= mem_addr + 1'b1;
                    end
                end
                SCAN: begin
                    // Address advances after every read but the last, so it
                    // rests on the final byte read once the scan ends.
                    rd_q <= mem_rd;
                    if (mem_rd) begin
                        rd_cnt <= rd_cnt + CW'(1);
                        if (rd_cnt != tot - CW'(1)) mem_addr <= mem_addr + 1'b1;
                    end
                    if (rd_q) begin
                        samp_cnt <= samp_cnt + CW'(1);
                        case (samp_cnt[1:0])
                            2'd0, 2'd1: cur_id <= {cur_id[WORD_WIDTH-9:0], mem_rdata};
                            2'd2:       val_hi <= mem_rdata;
                            default: if (better) begin
                                run_val <= cand;
                                run_id  <= cur_id;
                            end
                        endcase
                        if (last_sample) begin
                            wp_bestvalue      <= better ? cand : run_val;
                            wp_bestneighborID <= better ? cur_id : run_id;
                        end
                    end
                end
                KICK: wait_cnt <= '0;
                WAIT: begin
                    if (wp_done) begin
                        nexthop    <= wp_nexthop;
                        wp_besthop <= wp_nexthop;
                        wp_mybest  <= run_val;
                        wp_epsilon <= wp_epsilon_step;
                    end else if (timed_out) begin
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_scan_ctrl.sv
// Self-checking bench for neighbor_scan_ctrl: byte memory model, mock
// winnerPolicy, and a per-cycle schedule model derived from the table contents.
module tb_neighbor_scan_ctrl;

    localparam int TO   = 8;
    localparam int MAXN = 64;

    logic        clock = 1'b0;
    logic        nreset, start, eps_load;
    logic [9:0]  table_base;
    logic [15:0] my_node_id, eps_init;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [15:0] wp_epsilon, wp_mybest, wp_besthop, wp_bestvalue, wp_bestneighborID, wp_my_node_id;
    logic        wp_done_prev, wp_done;
    logic [15:0] wp_nexthop, wp_epsilon_step;
    logic        busy, round_done, no_route, timeout;
    logic [15:0] nexthop;

    neighbor_scan_ctrl #(
        .ADDR_WIDTH(10), .WORD_WIDTH(16), .MAX_NEIGHBORS(MAXN), .WP_TIMEOUT(TO)
    ) dut (
        .clock(clock), .nreset(nreset), .start(start), .table_base(table_base),
        .my_node_id(my_node_id), .eps_init(eps_init), .eps_load(eps_load),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .wp_epsilon(wp_epsilon), .wp_mybest(wp_mybest), .wp_besthop(wp_besthop),
        .wp_bestvalue(wp_bestvalue), .wp_bestneighborID(wp_bestneighborID),
        .wp_my_node_id(wp_my_node_id), .wp_done_prev(wp_done_prev), .wp_done(wp_done),
        .wp_nexthop(wp_nexthop), .wp_epsilon_step(wp_epsilon_step), .busy(busy),
        .round_done(round_done), .nexthop(nexthop), .no_route(no_route), .timeout(timeout)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] mem [1024];

    // round model
    bit          round_active = 1'b0;
    int          start_cyc, r_base, r_n, r_kick, r_done;
    logic [15:0] r_best, r_bid;
    int          kick_seen, done_seen, rd_seen;

    // persistent expected outputs
    logic [15:0] m_nh, m_bh, m_mb, m_eps, m_bv, m_bid;
    logic        m_noroute, m_timeout;

    bit          mock_on = 1'b0;
    int          mock_lat = 1;
    logic [15:0] mock_step = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic put16(input int addr, input logic [15:0] v);
        mem[addr % 1024]       = v[15:8];
        mem[(addr + 1) % 1024] = v[7:0];
    endtask

    // memory: 1-cycle read latency, garbage when not reading
    initial begin
        logic       rd;
        logic [9:0] a;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            rd = mem_rd;
            a  = mem_addr;
            @(posedge clock);
            #1 mem_rdata = rd ? mem[a] : 8'($urandom);
        end
    end

    // mock winnerPolicy: echoes the candidate ID after mock_lat cycles
    initial begin
        logic [15:0] nh;
        forever begin
            @(negedge clock);
            if (wp_done_prev && mock_on) begin
                nh = wp_bestneighborID;
                repeat (mock_lat) @(posedge clock);
                #1;
                wp_done = 1'b1;
                wp_nexthop = nh;
                wp_epsilon_step = mock_step;
                @(posedge clock);
                #1;
                wp_done = 1'b0;
                wp_nexthop = 16'($urandom);
            end
        end
    end

    // per-cycle compare against the round schedule
    always @(negedge clock) begin
        if (round_active) begin
            int rel;
            bit e_rd;
            rel  = cyc - start_cyc;
            e_rd = (rel == 1 || rel == 2 || (r_n > 0 && rel >= 4 && rel <= 3 + 4 * r_n));
            check($sformatf("mem_rd@%0d", rel), 32'(mem_rd), 32'(e_rd));
            if (e_rd) begin
                int ea;
                ea = (rel == 1) ? r_base : (rel == 2) ? r_base + 1 : r_base + 2 + (rel - 4);
                check($sformatf("mem_addr@%0d", rel), 32'(mem_addr), 32'(ea % 1024));
            end
            check($sformatf("wp_done_prev@%0d", rel), 32'(wp_done_prev), 32'(r_n > 0 && rel == r_kick));
            check($sformatf("round_done@%0d", rel), 32'(round_done), 32'(rel == r_done));
            check($sformatf("busy@%0d", rel), 32'(busy), 32'(rel >= 1 && rel <= r_done));
            if (r_n > 0 && rel == r_kick) begin
                check("kick_bestvalue", 32'(wp_bestvalue), 32'(r_best));
                check("kick_bestid", 32'(wp_bestneighborID), 32'(r_bid));
                check("kick_epsilon", 32'(wp_epsilon), 32'(m_eps));
                check("kick_my_node_id", 32'(wp_my_node_id), 32'(my_node_id));
            end
            if (mem_rd) rd_seen++;
            if (wp_done_prev && kick_seen < 0) kick_seen = rel;
            if (round_done && done_seen < 0) done_seen = rel;
        end
    end

    task automatic check_state(input string tag);
        @(negedge clock);
        check({tag, "_nexthop"}, 32'(nexthop), 32'(m_nh));
        check({tag, "_besthop"}, 32'(wp_besthop), 32'(m_bh));
        check({tag, "_mybest"}, 32'(wp_mybest), 32'(m_mb));
        check({tag, "_epsilon"}, 32'(wp_epsilon), 32'(m_eps));
        check({tag, "_bestvalue"}, 32'(wp_bestvalue), 32'(m_bv));
        check({tag, "_bestid"}, 32'(wp_bestneighborID), 32'(m_bid));
        check({tag, "_no_route"}, 32'(no_route), 32'(m_noroute));
        check({tag, "_timeout"}, 32'(timeout), 32'(m_timeout));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_my_node_id"}, 32'(wp_my_node_id), 32'(my_node_id));
    endtask

    task automatic run_round(input int base, input int lat, input bit respond,
                             input logic [15:0] step, input bit load_with_start,
                             input logic [15:0] eps_v, input bit noise);
        int n_raw;
        n_raw  = {mem[base % 1024], mem[(base + 1) % 1024]};
        r_n    = (n_raw > MAXN) ? MAXN : n_raw;
        r_best = 16'h7C00;
        r_bid  = '0;
        for (int i = 0; i < r_n; i++) begin
            int a;
            logic [15:0] id, v;
            a  = base + 2 + 4 * i;
            id = {mem[a % 1024], mem[(a + 1) % 1024]};
            v  = {mem[(a + 2) % 1024], mem[(a + 3) % 1024]};
            if (v < r_best) begin
                r_best = v;
                r_bid  = id;
            end
        end
        r_base = base;
        r_kick = 5 + 4 * r_n;
        r_done = (r_n == 0) ? 4 : respond ? 6 + 4 * r_n + lat : 5 + 4 * r_n + TO + 1;
        mock_on = respond;
        mock_lat = lat;
        mock_step = step;
        table_base = 10'(base);

        @(posedge clock);
        #1;
        start = 1'b1;
        if (load_with_start) begin
            eps_load = 1'b1;
            eps_init = eps_v;
            m_eps    = eps_v;
        end
        start_cyc = cyc;
        kick_seen = -1;
        done_seen = -1;
        rd_seen   = 0;
        round_active = 1'b1;
        @(posedge clock);
        #1;
        for (int c = 1; c <= r_done + 1; c++) begin
            if (noise && c == 6) begin
                start = 1'b1;
                eps_load = 1'b1;
                eps_init = 16'h1234;
            end else begin
                start = 1'b0;
                eps_load = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        eps_load = 1'b0;
        round_active = 1'b0;

        if (r_n == 0) begin
            m_noroute = 1'b1;
            m_timeout = 1'b0;
        end else begin
            m_bv = r_best;
            m_bid = r_bid;
            m_noroute = 1'b0;
            if (respond) begin
                m_nh = r_bid;
                m_bh = r_bid;
                m_mb = r_best;
                m_eps = step;
                m_timeout = 1'b0;
            end else begin
                m_timeout = 1'b1;
            end
        end
    endtask

    task automatic reset_model();
        m_nh = '0; m_bh = '0; m_mb = 16'h7C00; m_eps = '0; m_bv = '0; m_bid = '0;
        m_noroute = 1'b0; m_timeout = 1'b0;
    endtask

    initial begin
        nreset = 1'b1; start = 1'b0; eps_load = 1'b0; eps_init = '0;
        table_base = '0; my_node_id = 16'h0ABC;
        wp_done = 1'b0; wp_nexthop = '0; wp_epsilon_step = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        // basic table
        put16(16'h010, 16'd3);
        put16(16'h012, 16'h0011); put16(16'h014, 16'h3C00);
        put16(16'h016, 16'h0022); put16(16'h018, 16'h3800);
        put16(16'h01A, 16'h0033); put16(16'h01C, 16'h3800);
        // empty table
        put16(16'h100, 16'd0);
        // timeout table, wraps past the top of memory
        put16(16'h3FE, 16'd2);
        put16(16'h000, 16'h0100); put16(16'h002, 16'h4000);
        put16(16'h004, 16'h0200); put16(16'h006, 16'h3E00);
        // clamp table: entries past 63 are cheaper but must be ignored
        put16(16'h200, 16'd100);
        for (int i = 0; i < 100; i++) begin
            put16(16'h202 + 4 * i, 16'(16'h1000 + i));
            put16(16'h204 + 4 * i, (i < 64) ? 16'(16'h6000 - 16 * i) : 16'h0001);
        end
        reset_model();

        repeat (2) @(posedge clock);
        #1 nreset = 1'b0;
        @(negedge clock);
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_rd", 32'(mem_rd), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_round_done", 32'(round_done), 32'(0));
        check("rst_done_prev", 32'(wp_done_prev), 32'(0));
        check("rst_mybest", 32'(wp_mybest), 32'h7C00);
        check("rst_epsilon", 32'(wp_epsilon), 32'(0));
        check("rst_besthop", 32'(wp_besthop), 32'(0));
        check("rst_bestvalue", 32'(wp_bestvalue), 32'(0));
        check("rst_bestid", 32'(wp_bestneighborID), 32'(0));
        check("rst_my_node_id", 32'(wp_my_node_id), 32'(0));
        check("rst_nexthop", 32'(nexthop), 32'(0));
        check("rst_no_route", 32'(no_route), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));

        @(posedge clock);
        #1 eps_load = 1'b1; eps_init = 16'h3C00;
        @(posedge clock);
        #1 eps_load = 1'b0;
        m_eps = 16'h3C00;
        @(negedge clock);
        check("eps_load", 32'(wp_epsilon), 32'h3C00);

        run_round(16'h010, 1, 1'b1, 16'h3000, 1'b0, '0, 1'b0);
        check("basic_kick_cycle", 32'(kick_seen), 32'(17));
        check("basic_done_cycle", 32'(done_seen), 32'(19));
        check("basic_nexthop_lit", 32'(nexthop), 32'h0022);
        check("basic_eps_lit", 32'(wp_epsilon), 32'h3000);
        check("basic_mybest_lit", 32'(wp_mybest), 32'h3800);
        check("basic_bestid_lit", 32'(wp_bestneighborID), 32'h0022);
        check_state("basic");

        run_round(16'h100, 1, 1'b1, 16'h3000, 1'b0, '0, 1'b0);
        check("empty_done_cycle", 32'(done_seen), 32'(4));
        check("empty_no_kick", 32'(kick_seen), 32'(-1));
        check("empty_reads", 32'(rd_seen), 32'(2));
        check("empty_no_route_lit", 32'(no_route), 32'(1));
        check_state("empty");

        run_round(16'h3FE, 1, 1'b0, '0, 1'b0, '0, 1'b1);
        check("to_done_cycle", 32'(done_seen), 32'(22));
        check("to_timeout_lit", 32'(timeout), 32'(1));
        check("to_nexthop_lit", 32'(nexthop), 32'h0022);
        check("to_eps_lit", 32'(wp_epsilon), 32'h3000);
        check("to_bestid_lit", 32'(wp_bestneighborID), 32'h0200);
        check_state("timeout");

        run_round(16'h200, 3, 1'b1, 16'h2C00, 1'b1, 16'h3555, 1'b0);
        check("clamp_reads", 32'(rd_seen), 32'(2 + 256));
        check("clamp_done_cycle", 32'(done_seen), 32'(265));
        check("clamp_bestid_lit", 32'(wp_bestneighborID), 32'h103F);
        check("clamp_bestvalue_lit", 32'(wp_bestvalue), 32'h5C10);
        check_state("clamp");

        // reset in the middle of a scan
        begin
            int s;
            mock_on = 1'b0;
            table_base = 10'h010;
            @(posedge clock);
            #1 start = 1'b1;
            s = cyc;
            @(posedge clock);
            #1 start = 1'b0;
            while (cyc < s + 10) begin
                @(posedge clock);
                #1;
            end
            nreset = 1'b1;
            @(posedge clock);
            #1 nreset = 1'b0;
            @(negedge clock);
            check("mrst_busy", 32'(busy), 32'(0));
            check("mrst_mem_rd", 32'(mem_rd), 32'(0));
            check("mrst_mybest", 32'(wp_mybest), 32'h7C00);
            check("mrst_epsilon", 32'(wp_epsilon), 32'(0));
            check("mrst_nexthop", 32'(nexthop), 32'(0));
            check("mrst_bestid", 32'(wp_bestneighborID), 32'(0));
            reset_model();
            @(posedge clock);
            #1 wp_done = 1'b1; wp_nexthop = 16'hBEEF; wp_epsilon_step = 16'h1111;
            @(posedge clock);
            #1 wp_done = 1'b0;
            repeat (2) @(posedge clock);
            check_state("mrst");
        end

        my_node_id = 16'h0DEF;
        run_round(16'h010, 2, 1'b1, 16'h3400, 1'b0, '0, 1'b0);
        check("fresh_done_cycle", 32'(done_seen), 32'(20));
        check("fresh_nexthop_lit", 32'(nexthop), 32'h0022);
        check("fresh_eps_lit", 32'(wp_epsilon), 32'h3400);
        check_state("fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
